mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory slave with a fixed wait-state count, byte-lane core writes
// and an independent preload port. Out-of-range core accesses complete with mem_err.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [3:0]  mem_be,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [29:0] idx_reg, idx_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  be_reg, be_next;
    logic        write_reg, write_next;
    logic        ready_reg;
    logic        err_reg;

    logic        req;
    logic        enter_resp;
    logic [29:0] sel_idx;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_write;
    logic        sel_oor;
    logic        resp_oor;
    logic        core_wr;
    logic        load_wr;
    logic        rd_capture;
    logic        unused_bits;

    assign req         = mem_re | mem_we;
    assign unused_bits = ^mem_addr[1:0];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        wdata_next = wdata_reg;
        be_next    = be_reg;
        write_next = write_reg;
        enter_resp = 1'b0;
        sel_idx    = idx_reg;
        sel_wdata  = wdata_reg;
        sel_be     = be_reg;
        sel_write  = write_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    idx_next   = mem_addr[31:2];
                    wdata_next = mem_wdata;
                    be_next    = mem_be;
                    write_next = mem_we;
                    if (WAIT_STATES == 0) begin
                        // No wait states: the write commits on this very edge, so use the live request.
                        state_next = RESP;
                        enter_resp = 1'b1;
                        sel_idx    = mem_addr[31:2];
                        sel_wdata  = mem_wdata;
                        sel_be     = mem_be;
                        sel_write  = mem_we;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sel_oor    = ({2'b00, sel_idx} >= DEPTH_L);
    assign resp_oor   = ({2'b00, idx_reg} >= DEPTH_L);
    assign core_wr    = enter_resp & sel_write & ~sel_oor & ~rst;
    assign load_wr    = load_en & ~rst & (load_addr < DEPTH_L);
    assign rd_capture = (state_reg == RESP) & ~write_reg & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            write_reg <= 1'b0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            wdata_reg <= wdata_next;
            be_reg    <= be_next;
            write_reg <= write_next;
            ready_reg <= (state_reg == RESP);
            err_reg   <= (state_reg == RESP) & resp_oor;
        end
    end

    // One byte-wide store per lane; the core write is issued last so it wins a same-word collision.
    for (genvar gi = 0; gi < 4; gi++) begin : lane_g
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (load_wr) begin
                lane_mem[load_addr[AW-1:0]] <= load_data[8*gi +: 8];
            end
            if (core_wr && sel_be[gi]) begin
                lane_mem[sel_idx[AW-1:0]] <= sel_wdata[8*gi +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_reg <= 8'h00;
            end else if (rd_capture) begin
                rdata_reg <= resp_oor ? 8'h00 : lane_mem[idx_reg[AW-1:0]];
            end
        end

        assign mem_rdata[8*gi +: 8] = rdata_reg;
    end

    assign mem_ready = ready_reg;
    assign mem_err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_STATES=2 instance driven from a vector table plus corner
// sequences, and a WAIT_STATES=0 instance exercising a continuously held read.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_we, a_re, a_ready, a_err;
    logic [3:0]  a_be;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_we, b_re, b_ready, b_err;
    logic [3:0]  b_be;
    logic        load_en;
    logic [31:0] load_addr, load_data;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs [15];

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we), .mem_re(a_re), .mem_be(a_be),
        .mem_rdata(a_rdata), .mem_ready(a_ready), .mem_err(a_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we), .mem_re(b_re), .mem_be(b_be),
        .mem_rdata(b_rdata), .mem_ready(b_ready), .mem_err(b_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Scoreboard: every completion of the WAIT_STATES=2 instance pops one expectation.
    always @(negedge clk) begin
        if (a_ready) begin
            if (exp_q.size() == 0) begin
                chk("a_unexpected_ready", 32'(a_ready), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_rdata"}, a_rdata, mon_e.rdata);
                chk({mon_e.name, "_err"}, 32'(a_err), 32'(mon_e.err));
            end
        end
    end

    task automatic load(input logic [31:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; holds the request until mem_ready is seen.
    task automatic a_txn(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] erd, input logic eerr, input string name);
        int  lat;
        bit  seen;
        exp_q.push_back('{erd, eerr, name});
        a_we = we; a_re = re; a_addr = addr; a_wdata = wdata; a_be = be;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (a_ready) seen = 1'b1;
        end
        a_we = 1'b0;
        a_re = 1'b0;
        if (!seen) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
            if (exp_q.size() > 0) exp_q.delete(0);
        end else begin
            chk({name, "_latency"}, 32'(lat), 32'd4);
        end
    endtask

    // Request with a preload pulse on the load_at-th negedge after it is driven.
    task automatic a_with_load(input logic we, input logic re, input logic [31:0] addr,
                               input logic [31:0] wdata, input int load_at,
                               input logic [31:0] lidx, input logic [31:0] ldata,
                               input logic [31:0] erd, input string name);
        bit seen;
        exp_q.push_back('{erd, 1'b0, name});
        a_we = we; a_re = re; a_addr = addr; a_wdata = wdata; a_be = 4'hF;
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            load_en   = (n == load_at);
            load_addr = lidx;
            load_data = ldata;
            if (n == 3) begin
                a_we = 1'b0;
                a_re = 1'b0;
            end
            if (a_ready) seen = 1'b1;
        end
        load_en = 1'b0;
        a_we = 1'b0;
        a_re = 1'b0;
        if (!seen) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
            if (exp_q.size() > 0) exp_q.delete(0);
        end
    endtask

    logic [31:0] b_addrs [5];
    logic [31:0] b_datas [5];

    initial begin
        int cnt;
        int bi;
        checks = 0;
        failures = 0;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_000C, 32'h0000_0000, 4'h0, 32'hE10F_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0014, 32'hAABB_CCDD, 4'h5, 32'hE10F_0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005, 4'hF, 32'h11BB_33DD, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h0000_0005, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0005, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0BAD_F00D, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0000_0000, 4'h0, 32'h1357_9BDF, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0028, 32'h1234_5678, 4'h0, 32'h1357_9BDF, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_002B, 32'h0000_0000, 4'h0, 32'hCAFE_BABE, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_000F, 32'h0000_0000, 4'h0, 32'hE10F_0000, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_1004, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0017, 32'h9900_0000, 4'h8, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_0000, 4'h0, 32'h99BB_33DD, 1'b0};

        b_addrs[0] = 32'h0000_000C; b_datas[0] = 32'hE10F_0000;
        b_addrs[1] = 32'h0000_0014; b_datas[1] = 32'h1122_3344;
        b_addrs[2] = 32'h0000_0028; b_datas[2] = 32'hCAFE_BABE;
        b_addrs[3] = 32'h0000_0000; b_datas[3] = 32'h0BAD_F00D;
        b_addrs[4] = 32'h0000_0FFC; b_datas[4] = 32'h1357_9BDF;

        rst = 1'b1;
        a_addr = '0; a_wdata = '0; a_we = 1'b0; a_re = 1'b0; a_be = '0;
        b_addr = '0; b_wdata = '0; b_we = 1'b0; b_re = 1'b0; b_be = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_rdata", a_rdata, 32'd0);
        chk("reset_ready", 32'(a_ready), 32'd0);
        chk("reset_err", 32'(a_err), 32'd0);
        chk("reset_b_ready", 32'(b_ready), 32'd0);
        rst = 1'b0;

        load(32'd3,    32'hE10F_0000);
        load(32'd5,    32'h1122_3344);
        load(32'd10,   32'hCAFE_BABE);
        load(32'd0,    32'h0BAD_F00D);
        load(32'd1023, 32'h1357_9BDF);
        load(32'd12,   32'h1212_1212);
        load(32'd15,   32'h0F0F_0F0F);
        load(32'd16,   32'h0000_0016);
        load(32'd1024, 32'hDEAD_DEAD);

        for (int i = 0; i < 15; i++) begin
            a_txn(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                  vecs[i].erd, vecs[i].eerr, $sformatf("v%0d", i));
        end

        // Abort: write accepted, then both strobes dropped during the wait phase.
        a_we = 1'b1; a_addr = 32'h0000_0030; a_wdata = 32'h0; a_be = 4'hF;
        @(negedge clk);
        a_we = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_ready) cnt++;
        end
        chk("abort_no_ready", 32'(cnt), 32'd0);
        a_txn(1'b0, 1'b1, 32'h0000_0030, 32'h0, 4'h0, 32'h1212_1212, 1'b0, "abort_word_intact");

        // Reset during the wait phase of a write.
        a_we = 1'b1; a_addr = 32'h0000_0030; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_rdata", a_rdata, 32'd0);
        chk("rst_wait_ready", 32'(a_ready), 32'd0);
        chk("rst_wait_err", 32'(a_err), 32'd0);
        rst = 1'b0;
        a_we = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_ready) cnt++;
        end
        chk("rst_wait_no_ready", 32'(cnt), 32'd0);
        a_txn(1'b0, 1'b1, 32'h0000_0030, 32'h0, 4'h0, 32'h1212_1212, 1'b0, "rst_word_intact");
        a_txn(1'b0, 1'b1, 32'h0000_000C, 32'h0, 4'h0, 32'hE10F_0000, 1'b0, "rst_preload_intact");

        // Core write and preload hit word 14 on the same edge.
        a_with_load(1'b1, 1'b0, 32'h0000_0038, 32'hAAAA_0000, 2, 32'd14, 32'h5555_5555,
                    32'hE10F_0000, "collide_wr");
        a_txn(1'b0, 1'b1, 32'h0000_0038, 32'h0, 4'h0, 32'hAAAA_0000, 1'b0, "collide_core_wins");

        // Preload on the read-capture edge: old data is returned.
        a_with_load(1'b0, 1'b1, 32'h0000_003C, 32'h0, 3, 32'd15, 32'hF0F0_F0F0,
                    32'h0F0F_0F0F, "rd_old_data");
        a_txn(1'b0, 1'b1, 32'h0000_003C, 32'h0, 4'h0, 32'hF0F0_F0F0, 1'b0, "rd_new_data");

        // Preload attempted while reset is held.
        rst = 1'b1;
        load(32'd16, 32'hDEAD_0001);
        rst = 1'b0;
        a_txn(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0, 32'h0000_0016, 1'b0, "load_in_rst_ignored");

        // Zero wait states, read held high: completion every second cycle.
        bi = 0;
        b_re = 1'b1;
        b_addr = b_addrs[0];
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("b_ready_k%0d", k), 32'(b_ready), ((k % 2) == 0) ? 32'd1 : 32'd0);
            if (b_ready && bi < 5) begin
                chk($sformatf("b_rdata_%0d", bi), b_rdata, b_datas[bi]);
                chk($sformatf("b_err_%0d", bi), 32'(b_err), 32'd0);
                bi++;
                if (bi < 5) b_addr = b_addrs[bi];
            end
        end
        b_re = 1'b0;
        chk("b_reads_done", 32'(bi), 32'd5);

        repeat (3) @(negedge clk);
        chk("a_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
